qerv_bufreg_w: RTL and testbench

Width-generic successor of the bit-serial buffer register for W bits per cycle, W in {1,2,4,8}.
- Computes rs1+imm serially into a 32-bit shift register that drives the data-bus address.
- Aligns sub-beat shift amounts and supplies rotate fill for Zbb ror/rol.
- Adds synchronous reset, an internal beat counter with last-beat flag, and load/store misalignment detection.

---
 rtl/qerv_pkg.sv | 16 +
 rtl/qerv_shalign.sv | 65 ++++++
 rtl/qerv_bufreg_w.sv | 155 +++++++++++++++
 tb/tb_qerv_bufreg_w.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qerv_pkg.sv
// rtl/qerv_pkg.sv - shared constants and helpers for the W-bit buffer register
package qerv_pkg;

  localparam int XLEN = 32;

  // Access size encodings on i_size
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Enabled beats needed to move one XLEN word at w bits per beat
  function automatic int beats(input int w);
    return XLEN / w;
  endfunction

endpackage

// File: rtl/qerv_shalign.sv
// rtl/qerv_shalign.sv - sub-beat shift alignment with carried-over residual bits
module qerv_shalign
  import qerv_pkg::*;
#(
  parameter  int W  = 4,
  localparam int LB = $clog2(W)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic          i_cnt0,
  input  logic          i_shift_op,
  input  logic          i_right_shift_op,
  input  logic [LB:0]   i_shamt_lsb,
  input  logic [W-1:0]  i_data_lsb,
  output logic [W-1:0]  o_q
);

  localparam int          SW  = LB + 1;
  localparam logic [LB:0] W_L = SW'(W);

  logic [LB:0]    s;
  logic [2*W-1:0] wide;
  logic [2*W-1:0] residual_q;
  logic [2*W-1:0] residual_d;

  // Shift amount within a beat; a right shift by k is a left shift by W-k
  // of the word as it streams, with zero meaning no realignment at all.
  always_comb begin
    s = '0;
    if (i_shift_op) begin
      if (!i_right_shift_op) begin
        s = i_shamt_lsb;
      end else if (i_shamt_lsb != '0) begin
        s = W_L - i_shamt_lsb;
      end
    end
  end

  assign wide = {{W{1'b0}}, i_data_lsb} << s;

  // Residual keeps the bits pushed past this beat for the next one; a new
  // pass clears it unless a beat is being consumed at the same time.
  always_comb begin
    residual_d = residual_q;
    if (i_cnt0) begin
      residual_d = '0;
    end
    if (i_en) begin
      residual_d = wide;
    end
  end

  // Residual register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      residual_q <= '0;
    end else begin
      residual_q <= residual_d;
    end
  end

  assign o_q = i_en ? (wide[W-1:0] | residual_q[2*W-1:W]) : '0;

endmodule

// File: rtl/qerv_bufreg_w.sv
// rtl/qerv_bufreg_w.sv - W-bit-per-beat buffer register for address and shift data
module qerv_bufreg_w
  import qerv_pkg::*;
#(
  parameter  int W   = 4,
  parameter  int MDU = 0,
  parameter  int ROT = 0,
  localparam int LB  = $clog2(W)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_cnt0,
  input  logic          i_en,
  input  logic          i_init,
  input  logic          i_mdu_op,
  input  logic          i_rs1_en,
  input  logic          i_imm_en,
  input  logic          i_clr_lsb,
  input  logic          i_shift_op,
  input  logic          i_right_shift_op,
  input  logic          i_sh_signed,
  input  logic          i_rot_op,
  input  logic [1:0]    i_size,
  input  logic [W-1:0]  i_rs1,
  input  logic [W-1:0]  i_imm,
  input  logic [LB:0]   i_shamt_lsb,
  output logic [W-1:0]  o_q,
  output logic [1:0]    o_lsb,
  output logic          o_misalign,
  output logic          o_last,
  output logic [31:0]   o_dbus_adr,
  output logic [31:0]   o_ext_rs1
);

  if (!(W == 1 || W == 2 || W == 4 || W == 8)) begin : g_bad_w
    $error("qerv_bufreg_w: W must be 1, 2, 4 or 8");
  end

  localparam int            BW        = 5 - LB;
  localparam logic [BW-1:0] LAST_BEAT = BW'(beats(W) - 1);
  localparam logic          ROT_EN    = (ROT != 0);
  localparam logic          MDU_EN    = (MDU != 0);

  logic [31:0]   data_q, data_d;
  logic          c_q, c_d;
  logic [1:0]    lsb_q, lsb_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [W-1:0]  rs1_g, imm_g, q, fill;
  logic [W:0]    sum;

  // Serial adder slice; carry only survives into an enabled following beat
  always_comb begin
    rs1_g = i_rs1_en ? i_rs1 : '0;
    imm_g = i_imm_en ? i_imm : '0;
    if (i_cnt0 && i_clr_lsb) begin
      imm_g[0] = 1'b0;
    end
    sum = {1'b0, rs1_g} + {1'b0, imm_g} + {{W{1'b0}}, c_q};
    q   = sum[W-1:0];
    c_d = sum[W] & i_en;
  end

  // Bits entering the top of the word: adder, rotate, sign or zero
  always_comb begin
    if (i_init) begin
      fill = q;
    end else if (ROT_EN && i_rot_op) begin
      fill = data_q[W-1:0];
    end else if (i_sh_signed) begin
      fill = {W{data_q[31]}};
    end else begin
      fill = '0;
    end
  end

  // Word shift and beat counter; a first beat resynchronises the count
  always_comb begin
    data_d = data_q;
    beat_d = beat_q;
    if (i_en) begin
      data_d = {fill, data_q[31:W]};
      if (i_cnt0) begin
        beat_d = BW'(1);
      end else if (beat_q == LAST_BEAT) begin
        beat_d = '0;
      end else begin
        beat_d = beat_q + BW'(1);
      end
    end
  end

  if (W == 1) begin : g_lsb_serial
    // One address bit per beat: bit 0 on the first beat, bit 1 on the second
    always_comb begin
      lsb_d = lsb_q;
      if (i_en && i_cnt0) begin
        lsb_d[0] = q[0];
      end
      if (i_en && beat_q == BW'(1)) begin
        lsb_d[1] = q[0];
      end
    end
  end else begin : g_lsb_wide
    // Both address bits come out of the first beat
    always_comb begin
      lsb_d = lsb_q;
      if (i_en && i_cnt0) begin
        lsb_d = q[1:0];
      end
    end
  end

  // State registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      data_q <= '0;
      c_q    <= 1'b0;
      lsb_q  <= '0;
      beat_q <= '0;
    end else begin
      data_q <= data_d;
      c_q    <= c_d;
      lsb_q  <= lsb_d;
      beat_q <= beat_d;
    end
  end

  qerv_shalign #(.W(W)) u_shalign (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_en             (i_en),
    .i_cnt0           (i_cnt0),
    .i_shift_op       (i_shift_op),
    .i_right_shift_op (i_right_shift_op),
    .i_shamt_lsb      (i_shamt_lsb),
    .i_data_lsb       (data_q[W-1:0]),
    .o_q              (o_q)
  );

  // Alignment check against the captured address bits
  always_comb begin
    case (i_size)
      SZ_B:    o_misalign = 1'b0;
      SZ_H:    o_misalign = lsb_q[0];
      SZ_W:    o_misalign = |lsb_q;
      default: o_misalign = 1'b0;
    endcase
  end

  assign o_lsb      = (MDU_EN && i_mdu_op) ? 2'b00 : lsb_q;
  assign o_last     = i_en & (beat_q == LAST_BEAT);
  assign o_dbus_adr = {data_q[31:2], 2'b00};
  assign o_ext_rs1  = {data_q[31:2], lsb_q};

endmodule

// File: tb/tb_qerv_bufreg_w.sv
// tb/tb_qerv_bufreg_w.sv - self-checking bench for qerv_bufreg_w at W=1,2,4,8
module tb_qerv_bufreg_w;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, cnt0, init, mdu_op, rs1_en, imm_en, clr_lsb;
  logic shift_op, right_op, sgn, rot;
  logic [1:0] size;
  logic en1, en2, en4, en8;
  logic [0:0] rs1_1, imm_1, sh_1;
  logic [1:0] rs1_2, imm_2, sh_2;
  logic [3:0] rs1_4, imm_4;
  logic [2:0] sh_4;
  logic [7:0] rs1_8, imm_8;
  logic [3:0] sh_8;
  int shamt = 0;

  logic [0:0] q_1;
  logic [1:0] q_2;
  logic [3:0] q_4;
  logic [7:0] q_8;
  logic [1:0] lsb_1, lsb_2, lsb_4, lsb_8;
  logic mis_1, mis_2, mis_4, mis_8;
  logic last_1, last_2, last_4, last_8;
  logic [31:0] adr_1, adr_2, adr_4, adr_8;
  logic [31:0] ext_1, ext_2, ext_4, ext_8;

  int cur_w = 4;
  logic [7:0] q_a;
  logic [1:0] lsb_a;
  logic last_a;
  logic [31:0] adr_a;

  int n_checks = 0;
  int n_pass = 0;

  always_comb begin
    sh_1 = 1'b0;
    sh_2 = 2'(shamt % 2);
    sh_4 = 3'(shamt % 4);
    sh_8 = 4'(shamt % 8);
  end

  always_comb begin
    q_a = '0; lsb_a = '0; last_a = 1'b0; adr_a = '0;
    case (cur_w)
      1: begin q_a = 8'(q_1); lsb_a = lsb_1; last_a = last_1; adr_a = adr_1; end
      2: begin q_a = 8'(q_2); lsb_a = lsb_2; last_a = last_2; adr_a = adr_2; end
      4: begin q_a = 8'(q_4); lsb_a = lsb_4; last_a = last_4; adr_a = adr_4; end
      default: begin q_a = q_8; lsb_a = lsb_8; last_a = last_8; adr_a = adr_8; end
    endcase
  end

  qerv_bufreg_w #(.W(4), .MDU(1), .ROT(1)) u_w4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cnt0(cnt0), .i_en(en4), .i_init(init),
    .i_mdu_op(mdu_op), .i_rs1_en(rs1_en), .i_imm_en(imm_en), .i_clr_lsb(clr_lsb),
    .i_shift_op(shift_op), .i_right_shift_op(right_op), .i_sh_signed(sgn),
    .i_rot_op(rot), .i_size(size), .i_rs1(rs1_4), .i_imm(imm_4), .i_shamt_lsb(sh_4),
    .o_q(q_4), .o_lsb(lsb_4), .o_misalign(mis_4), .o_last(last_4),
    .o_dbus_adr(adr_4), .o_ext_rs1(ext_4));

  qerv_bufreg_w #(.W(1)) u_w1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cnt0(cnt0), .i_en(en1), .i_init(init),
    .i_mdu_op(mdu_op), .i_rs1_en(rs1_en), .i_imm_en(imm_en), .i_clr_lsb(clr_lsb),
    .i_shift_op(shift_op), .i_right_shift_op(right_op), .i_sh_signed(sgn),
    .i_rot_op(rot), .i_size(size), .i_rs1(rs1_1), .i_imm(imm_1), .i_shamt_lsb(sh_1),
    .o_q(q_1), .o_lsb(lsb_1), .o_misalign(mis_1), .o_last(last_1),
    .o_dbus_adr(adr_1), .o_ext_rs1(ext_1));

  qerv_bufreg_w #(.W(2)) u_w2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cnt0(cnt0), .i_en(en2), .i_init(init),
    .i_mdu_op(mdu_op), .i_rs1_en(rs1_en), .i_imm_en(imm_en), .i_clr_lsb(clr_lsb),
    .i_shift_op(shift_op), .i_right_shift_op(right_op), .i_sh_signed(sgn),
    .i_rot_op(rot), .i_size(size), .i_rs1(rs1_2), .i_imm(imm_2), .i_shamt_lsb(sh_2),
    .o_q(q_2), .o_lsb(lsb_2), .o_misalign(mis_2), .o_last(last_2),
    .o_dbus_adr(adr_2), .o_ext_rs1(ext_2));

  qerv_bufreg_w #(.W(8)) u_w8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cnt0(cnt0), .i_en(en8), .i_init(init),
    .i_mdu_op(mdu_op), .i_rs1_en(rs1_en), .i_imm_en(imm_en), .i_clr_lsb(clr_lsb),
    .i_shift_op(shift_op), .i_right_shift_op(right_op), .i_sh_signed(sgn),
    .i_rot_op(rot), .i_size(size), .i_rs1(rs1_8), .i_imm(imm_8), .i_shamt_lsb(sh_8),
    .o_q(q_8), .o_lsb(lsb_8), .o_misalign(mis_8), .o_last(last_8),
    .o_dbus_adr(adr_8), .o_ext_rs1(ext_8));

  // Reference: word-level address sum with optional bit-0 clear
  function automatic logic [31:0] m_sum(input logic [31:0] a, input logic [31:0] b,
                                        input logic ae, input logic be, input logic clr);
    logic [31:0] bb;
    bb = be ? b : 32'h0;
    if (clr) bb[0] = 1'b0;
    return (ae ? a : 32'h0) + bb;
  endfunction

  // Reference: effective left shift of the streamed word
  function automatic int m_s(input int w, input logic sh, input logic r, input int amt);
    if (!sh) return 0;
    if (!r) return amt;
    return (amt == 0) ? 0 : w - amt;
  endfunction

  // Reference: word left behind by a non-init pass
  function automatic logic [31:0] m_after(input logic [31:0] d, input logic rot_eff,
                                          input logic s_signed);
    if (rot_eff) return d;
    if (s_signed) return {32{d[31]}};
    return 32'h0;
  endfunction

  function automatic logic m_mis(input logic [1:0] sz, input logic [1:0] l);
    return (sz == 2'd1 && l[0]) || (sz == 2'd2 && l != 2'b00);
  endfunction

  task automatic drive_beat(input int w, input int b, input logic [31:0] rs1w, input logic [31:0] immw);
    cnt0 = (b == 0);
    en1 = (w == 1); en2 = (w == 2); en4 = (w == 4); en8 = (w == 8);
    rs1_1 = 1'(rs1w >> b);       imm_1 = 1'(immw >> b);
    rs1_2 = 2'(rs1w >> (2 * b)); imm_2 = 2'(immw >> (2 * b));
    rs1_4 = 4'(rs1w >> (4 * b)); imm_4 = 4'(immw >> (4 * b));
    rs1_8 = 8'(rs1w >> (8 * b)); imm_8 = 8'(immw >> (8 * b));
  endtask

  // One idle cycle with cnt0 (clears residual and carry), then a full pass
  task automatic run_pass(input int w, input logic [31:0] rs1w, input logic [31:0] immw,
                          output logic [31:0] stream, output int nlast, output int last_at);
    @(negedge clk);
    en1 = 0; en2 = 0; en4 = 0; en8 = 0; cnt0 = 1'b1;
    cur_w = w; stream = '0; nlast = 0; last_at = -1;
    for (int b = 0; b < 32 / w; b++) begin
      @(negedge clk);
      drive_beat(w, b, rs1w, immw);
      #1;
      stream = stream | (32'(q_a) << (b * w));
      if (last_a) begin nlast++; last_at = b; end
    end
    @(negedge clk);
    en1 = 0; en2 = 0; en4 = 0; en8 = 0; cnt0 = 1'b0;
    #1;
  endtask

  task automatic load_word(input int w, input logic [31:0] v);
    logic [31:0] st; int nl, la;
    init = 1; rs1_en = 1; imm_en = 0; clr_lsb = 0; shift_op = 0; sgn = 0; rot = 0;
    run_pass(w, v, 32'h0, st, nl, la);
    init = 0; rs1_en = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    @(negedge clk); @(negedge clk);
    en4 = 1; #1;
    n_checks++; if (adr_4 !== 32'h0) $display("FAIL reset_adr4 got %h exp 0", adr_4); else n_pass++;
    n_checks++; if (lsb_4 !== 2'b00) $display("FAIL reset_lsb4 got %b exp 00", lsb_4); else n_pass++;
    n_checks++; if (last_4 !== 1'b0) $display("FAIL reset_last4 got %b exp 0", last_4); else n_pass++;
    n_checks++; if (q_4 !== 4'h0) $display("FAIL reset_q4 got %h exp 0", q_4); else n_pass++;
    n_checks++; if ({adr_1, adr_2, adr_8} !== 96'h0) $display("FAIL reset_adr_other got %h exp 0", {adr_1, adr_2, adr_8}); else n_pass++;
    @(negedge clk);
    en4 = 0; rst_n = 1;
  endtask

  task automatic test_init_sum();
    logic [31:0] st; int nl, la;
    init = 1; rs1_en = 1; imm_en = 1; clr_lsb = 0;
    run_pass(4, 32'h00001003, 32'h5, st, nl, la);
    n_checks++; if (adr_4 !== 32'h00001008) $display("FAIL init_adr got %h exp 00001008", adr_4); else n_pass++;
    n_checks++; if (lsb_4 !== 2'b00) $display("FAIL init_lsb got %b exp 00", lsb_4); else n_pass++;
    n_checks++; if (nl !== 1 || la !== 7) $display("FAIL init_last got count=%0d beat=%0d exp count=1 beat=7", nl, la); else n_pass++;
    n_checks++; if (q_4 !== 4'h0) $display("FAIL idle_q got %h exp 0", q_4); else n_pass++;
  endtask

  task automatic test_clr_lsb_misalign();
    logic [31:0] st; int nl, la;
    init = 1; rs1_en = 1; imm_en = 1; clr_lsb = 1;
    run_pass(4, 32'h00001001, 32'h3, st, nl, la);
    clr_lsb = 0;
    n_checks++; if (adr_4 !== 32'h00001000) $display("FAIL clr_adr got %h exp 00001000", adr_4); else n_pass++;
    n_checks++; if (lsb_4 !== 2'b11) $display("FAIL clr_lsb got %b exp 11", lsb_4); else n_pass++;
    n_checks++; if (ext_4 !== 32'h00001003) $display("FAIL clr_ext got %h exp 00001003", ext_4); else n_pass++;
    for (int sz = 0; sz < 4; sz++) begin
      size = 2'(sz); #1;
      n_checks++;
      if (mis_4 !== m_mis(2'(sz), 2'b11)) $display("FAIL misalign_sz%0d got %b exp %b", sz, mis_4, m_mis(2'(sz), 2'b11));
      else n_pass++;
    end
  endtask

  task automatic test_shift();
    logic [31:0] st; int nl, la;
    load_word(4, 32'h80000001);
    shift_op = 1; right_op = 0; shamt = 1; sgn = 0;
    run_pass(4, 32'h0, 32'h0, st, nl, la);
    n_checks++; if (st !== 32'h00000002) $display("FAIL shl_stream got %h exp 00000002", st); else n_pass++;
    n_checks++; if (adr_4 !== 32'h0) $display("FAIL shl_refill got %h exp 0", adr_4); else n_pass++;
    load_word(4, 32'h80000001);
    shift_op = 1; right_op = 1; shamt = 1; sgn = 1;
    run_pass(4, 32'h0, 32'h0, st, nl, la);
    n_checks++; if (st !== 32'h00000008) $display("FAIL sra_stream got %h exp 00000008", st); else n_pass++;
    n_checks++; if (adr_4 !== 32'hFFFFFFFC) $display("FAIL sra_refill got %h exp FFFFFFFC", adr_4); else n_pass++;
    shift_op = 0; right_op = 0; shamt = 0; sgn = 0;
  endtask

  task automatic test_rotate();
    logic [31:0] st; int nl, la;
    load_word(4, 32'h80000001);
    rot = 1;
    run_pass(4, 32'h0, 32'h0, st, nl, la);
    n_checks++; if (st !== 32'h80000001) $display("FAIL rot_stream got %h exp 80000001", st); else n_pass++;
    n_checks++; if (adr_4 !== 32'h80000000) $display("FAIL rot_keep got %h exp 80000000", adr_4); else n_pass++;
    rot = 0;
    run_pass(4, 32'h0, 32'h0, st, nl, la);
    n_checks++; if (st !== 32'h80000001) $display("FAIL norot_stream got %h exp 80000001", st); else n_pass++;
    n_checks++; if (adr_4 !== 32'h0) $display("FAIL norot_zero got %h exp 0", adr_4); else n_pass++;
    load_word(8, 32'h80000001);
    rot = 1;
    run_pass(8, 32'h0, 32'h0, st, nl, la);
    rot = 0;
    n_checks++; if (adr_8 !== 32'h0) $display("FAIL rot_unbuilt got %h exp 0", adr_8); else n_pass++;
  endtask

  task automatic test_widths();
    logic [31:0] st; int nl, la, w;
    for (int i = 0; i < 3; i++) begin
      w = (i == 0) ? 1 : (i == 1) ? 2 : 8;
      init = 1; rs1_en = 1; imm_en = 1; clr_lsb = 0;
      run_pass(w, 32'h0000000F, 32'h1, st, nl, la);
      n_checks++; if (adr_a !== 32'h00000010) $display("FAIL carry_w%0d got %h exp 00000010", w, adr_a); else n_pass++;
      n_checks++; if (lsb_a !== 2'b00) $display("FAIL carry_lsb_w%0d got %b exp 00", w, lsb_a); else n_pass++;
      n_checks++; if (nl !== 1 || la !== 32 / w - 1) $display("FAIL last_w%0d got count=%0d beat=%0d exp beat=%0d", w, nl, la, 32 / w - 1); else n_pass++;
      run_pass(w, 32'h00000002, 32'h1, st, nl, la);
      n_checks++; if (lsb_a !== 2'b11) $display("FAIL lsb11_w%0d got %b exp 11", w, lsb_a); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_pass();
    logic [31:0] st; int nl, la;
    init = 1; rs1_en = 1; imm_en = 0; clr_lsb = 0;
    cur_w = 4;
    @(negedge clk); cnt0 = 1;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      drive_beat(4, b, 32'hFFFFFFFF, 32'h0);
    end
    @(negedge clk);
    drive_beat(4, 3, 32'hFFFFFFFF, 32'h0);
    rst_n = 0;
    @(negedge clk); #1;
    n_checks++; if (adr_4 !== 32'h0) $display("FAIL abort_adr got %h exp 0", adr_4); else n_pass++;
    n_checks++; if (lsb_4 !== 2'b00) $display("FAIL abort_lsb got %b exp 00", lsb_4); else n_pass++;
    n_checks++; if (last_4 !== 1'b0) $display("FAIL abort_beat got last=%b exp 0", last_4); else n_pass++;
    en4 = 0; rst_n = 1;
    imm_en = 1;
    run_pass(4, 32'h00001001, 32'h2, st, nl, la);
    n_checks++; if (ext_4 !== 32'h00001003) $display("FAIL clean_sum got %h exp 00001003", ext_4); else n_pass++;
    n_checks++; if (nl !== 1 || la !== 7) $display("FAIL clean_last got count=%0d beat=%0d exp 1/7", nl, la); else n_pass++;
    mdu_op = 1; #1;
    n_checks++; if (lsb_4 !== 2'b00) $display("FAIL mdu_lsb got %b exp 00", lsb_4); else n_pass++;
    mdu_op = 0; #1;
    n_checks++; if (lsb_4 !== 2'b11) $display("FAIL nomdu_lsb got %b exp 11", lsb_4); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] st, a, b, exp_sum, exp_data;
    logic ae, be, clr, r_rot, r_sgn;
    int nl, la, w, s;
    for (int it = 0; it < 12; it++) begin
      w = (it % 2 == 0) ? 4 : 8;
      a = $urandom; b = $urandom;
      ae = 1'($urandom); be = 1'($urandom); clr = 1'($urandom);
      init = 1; rs1_en = ae; imm_en = be; clr_lsb = clr;
      shift_op = 1'($urandom); right_op = 1'($urandom); shamt = 0;
      rot = 1'($urandom); sgn = 1'($urandom);
      run_pass(w, a, b, st, nl, la);
      exp_sum = m_sum(a, b, ae, be, clr);
      n_checks++; if (adr_a !== {exp_sum[31:2], 2'b00}) $display("FAIL rnd_adr it%0d got %h exp %h", it, adr_a, {exp_sum[31:2], 2'b00}); else n_pass++;
      n_checks++; if (lsb_a !== exp_sum[1:0]) $display("FAIL rnd_lsb it%0d got %b exp %b", it, lsb_a, exp_sum[1:0]); else n_pass++;
      size = 2'($urandom); #1;
      n_checks++;
      if ((w == 4 ? mis_4 : mis_8) !== m_mis(size, exp_sum[1:0])) $display("FAIL rnd_mis it%0d got %b exp %b", it, (w == 4 ? mis_4 : mis_8), m_mis(size, exp_sum[1:0]));
      else n_pass++;
      init = 0; rs1_en = 0; imm_en = 0; clr_lsb = 0;
      shift_op = 1'($urandom); right_op = 1'($urandom); shamt = $urandom_range(0, w - 1);
      r_rot = 1'($urandom); r_sgn = 1'($urandom); rot = r_rot; sgn = r_sgn;
      run_pass(w, 32'h0, 32'h0, st, nl, la);
      s = m_s(w, shift_op, right_op, shamt);
      exp_data = m_after(exp_sum, r_rot && (w == 4), r_sgn);
      n_checks++; if (st !== (exp_sum << s)) $display("FAIL rnd_stream it%0d got %h exp %h", it, st, exp_sum << s); else n_pass++;
      n_checks++; if (adr_a !== {exp_data[31:2], 2'b00}) $display("FAIL rnd_refill it%0d got %h exp %h", it, adr_a, {exp_data[31:2], 2'b00}); else n_pass++;
    end
    shift_op = 0; right_op = 0; shamt = 0; rot = 0; sgn = 0;
  endtask

  initial begin
    rst_n = 0; cnt0 = 0; init = 0; mdu_op = 0; rs1_en = 0; imm_en = 0; clr_lsb = 0;
    shift_op = 0; right_op = 0; sgn = 0; rot = 0; size = 2'd0;
    en1 = 0; en2 = 0; en4 = 0; en8 = 0;
    rs1_1 = '0; imm_1 = '0; rs1_2 = '0; imm_2 = '0;
    rs1_4 = '0; imm_4 = '0; rs1_8 = '0; imm_8 = '0;
    test_reset();
    test_init_sum();
    test_clr_lsb_misalign();
    test_shift();
    test_rotate();
    test_widths();
    test_reset_mid_pass();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
